// File: rtl/ppi_bus_master_if.sv
// Host request/response handshake plus the PPI bus control pins.
// The tri-state data bus is carried as a separate inout port on the master.
interface ppi_bus_master_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [1:0] req_addr;
   logic [7:0] req_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       busy;
   logic       cs;
   logic       wrb;
   logic       rdb;
   logic       a1;
   logic       a0;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, busy, cs, wrb, rdb, a1, a0
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, busy, cs, wrb, rdb, a1, a0
   );
endinterface

// File: rtl/ppi_bus_master.sv
// Synchronous initiator for an 8255-style PPI bus: turns single host requests
// into setup / strobe / hold phases on registered bus pins.
module ppi_bus_master #(
   parameter int SETUP_CYCLES  = 1,
   parameter int STROBE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 1
) (
   input  logic              clk,
   input  logic              reset,
   ppi_bus_master_if.master  bus,
   inout  wire  [7:0]        data
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

   localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
   localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       wr_q, wr_d;
   logic [1:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic [7:0] rdata_q, rdata_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       cs_q, cs_d;
   logic       wrb_q, wrb_d;
   logic       rdb_q, rdb_d;
   logic       oe_q, oe_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               wr_d    = bus.req_write;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               cnt_d   = SETUP_LD;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == 4'd0) begin
               cnt_d   = STROBE_LD;
               state_d = STROBE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         STROBE: begin
            if (cnt_q == 4'd0) begin
               // Last strobe cycle: the PPI has had the full strobe width to drive data.
               if (!wr_q) rdata_d = data;
               cnt_d   = HOLD_LD;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         HOLD: begin
            if (cnt_q == 4'd0) begin
               rsp_valid_d = 1'b1;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pins are decoded from the next state so they change exactly on the phase edge.
      cs_d  = (state_d == IDLE);
      wrb_d = !((state_d == STROBE) && wr_d);
      rdb_d = !((state_d == STROBE) && !wr_d);
      oe_d  = wr_d && (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         wr_q        <= 1'b0;
         addr_q      <= 2'b00;
         wdata_q     <= 8'h00;
         rdata_q     <= 8'h00;
         rsp_valid_q <= 1'b0;
         cs_q        <= 1'b1;
         wrb_q       <= 1'b1;
         rdb_q       <= 1'b1;
         oe_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         rsp_valid_q <= rsp_valid_d;
         cs_q        <= cs_d;
         wrb_q       <= wrb_d;
         rdb_q       <= rdb_d;
         oe_q        <= oe_d;
      end
   end

   assign bus.req_ready = (state_q == IDLE) && !reset;
   assign bus.busy      = (state_q != IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.cs        = cs_q;
   assign bus.wrb       = wrb_q;
   assign bus.rdb       = rdb_q;
   assign bus.a1        = addr_q[1];
   assign bus.a0        = addr_q[0];
   assign data          = oe_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed bench: default-timing master plus a stretched-timing master, each
// attached to a small PPI stand-in that latches writes and drives read data.
module tb_ppi_bus_master;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ppi_bus_master_if b1 ();
   ppi_bus_master_if b2 ();
   wire [7:0] data1;
   wire [7:0] data2;

   logic       sel;
   logic       rv;
   logic       rw;
   logic [1:0] ra;
   logic [7:0] rwd;

   assign b1.req_valid = rv & ~sel;
   assign b1.req_write = rw;
   assign b1.req_addr  = ra;
   assign b1.req_wdata = rwd;
   assign b2.req_valid = rv & sel;
   assign b2.req_write = rw;
   assign b2.req_addr  = ra;
   assign b2.req_wdata = rwd;

   ppi_bus_master u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (b1),
      .data  (data1)
   );

   ppi_bus_master #(
      .SETUP_CYCLES  (3),
      .STROBE_CYCLES (4),
      .HOLD_CYCLES   (2)
   ) u_dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (b2),
      .data  (data2)
   );

   // PPI stand-in: external pin values returned on reads, writes latched on wrb rise.
   logic [7:0] ext_pins [4];
   logic [7:0] seen     [4];
   assign data1 = (!b1.rdb && !b1.cs) ? ext_pins[{b1.a1, b1.a0}] : 8'hzz;
   assign data2 = (!b2.rdb && !b2.cs) ? ext_pins[{b2.a1, b2.a0}] : 8'hzz;
   always @(posedge b1.wrb) if (b1.cs === 1'b0) seen[{b1.a1, b1.a0}] <= data1;

   wire       cs_m   = sel ? b2.cs        : b1.cs;
   wire       wrb_m  = sel ? b2.wrb       : b1.wrb;
   wire       rdb_m  = sel ? b2.rdb       : b1.rdb;
   wire       rsp_m  = sel ? b2.rsp_valid : b1.rsp_valid;
   wire       rdy_m  = sel ? b2.req_ready : b1.req_ready;
   wire       busy_m = sel ? b2.busy      : b1.busy;
   wire [7:0] rd_m   = sel ? b2.rsp_rdata : b1.rsp_rdata;
   wire [7:0] dat_m  = sel ? data2        : data1;
   wire [1:0] a_m    = sel ? {b2.a1, b2.a0} : {b1.a1, b1.a0};

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // Strobe safety on both masters whenever a strobe is low.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (!b1.wrb || !b1.rdb) begin
            chk("one_strobe_1", 8'(b1.wrb | b1.rdb), 8'h01);
            chk("strobe_cs_1", 8'(b1.cs), 8'h00);
         end
         if (!b2.wrb || !b2.rdb) begin
            chk("one_strobe_2", 8'(b2.wrb | b2.rdb), 8'h01);
            chk("strobe_cs_2", 8'(b2.cs), 8'h00);
         end
      end
   end

   // One complete transaction on the selected master, checked cycle by cycle.
   task automatic run_txn(input logic s, input int S, input int W, input int H,
                          input logic wr, input logic [1:0] ad,
                          input logic [7:0] wd, input logic [7:0] exp_rd);
      int   tot;
      logic strobe;
      logic last;
      tot = S + W + H + 1;
      @(negedge clk);
      sel = s; rw = wr; ra = ad; rwd = wd; rv = 1'b1;
      #1 chk("ready_idle", 8'(rdy_m), 8'h01);
      @(posedge clk);
      for (int c = 1; c <= tot; c++) begin
         @(negedge clk);
         if (c == 1) rv = 1'b0;
         strobe = (c > S) && (c <= S + W);
         last   = (c == tot);
         chk("cs",        8'(cs_m),   8'(last));
         chk("wrb",       8'(wrb_m),  8'(!(strobe && wr)));
         chk("rdb",       8'(rdb_m),  8'(!(strobe && !wr)));
         chk("rsp_valid", 8'(rsp_m),  8'(last));
         chk("req_ready", 8'(rdy_m),  8'(last));
         chk("busy",      8'(busy_m), 8'(!last));
         chk("addr",      8'(a_m),    8'(ad));
         if (wr && !last) chk("wdata_bus", dat_m, wd);
         if (last) chk("rsp_rdata", rd_m, exp_rd);
      end
   endtask

   typedef struct packed {
      logic       wr;
      logic [1:0] ad;
      logic [7:0] wd;
      logic [7:0] rd;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{1'b1, 2'd3, 8'h80, 8'h00};
      tbl[1] = '{1'b1, 2'd0, 8'hBC, 8'h00};
      tbl[2] = '{1'b1, 2'd3, 8'h9B, 8'h00};
      tbl[3] = '{1'b0, 2'd1, 8'h00, 8'h35};
      tbl[4] = '{1'b0, 2'd0, 8'h00, 8'hC3};
      tbl[5] = '{1'b1, 2'd2, 8'h5A, 8'hC3};
      ext_pins[0] = 8'hC3; ext_pins[1] = 8'h35; ext_pins[2] = 8'h98; ext_pins[3] = 8'h00;
      for (int i = 0; i < 4; i++) seen[i] = 8'h00;
      sel = 1'b0; rv = 1'b0; rw = 1'b0; ra = 2'd0; rwd = 8'h00; reset = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_cs",        8'(cs_m),   8'h01);
      chk("rst_wrb",       8'(wrb_m),  8'h01);
      chk("rst_rdb",       8'(rdb_m),  8'h01);
      chk("rst_addr",      8'(a_m),    8'h00);
      chk("rst_rsp_valid", 8'(rsp_m),  8'h00);
      chk("rst_rdata",     rd_m,       8'h00);
      chk("rst_busy",      8'(busy_m), 8'h00);
      chk("rst_ready",     8'(rdy_m),  8'h00);
      rv = 1'b1; rw = 1'b1; ra = 2'd1; rwd = 8'hFF;
      @(negedge clk);
      chk("rst_ignore_req", 8'(busy_m), 8'h00);
      rv = 1'b0;
      reset = 1'b0;

      for (int i = 0; i < 6; i++) begin
         run_txn(1'b0, 1, 2, 1, tbl[i].wr, tbl[i].ad, tbl[i].wd, tbl[i].rd);
         if (tbl[i].wr) chk("ppi_latch", seen[tbl[i].ad], tbl[i].wd);
      end
      repeat (3) @(negedge clk);
      chk("addr_held_idle", 8'(a_m), 8'h02);

      // Back-to-back: write port A, then read port C accepted in the response cycle.
      @(negedge clk);
      sel = 1'b0; rw = 1'b1; ra = 2'd0; rwd = 8'h11; rv = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rw = 1'b0; ra = 2'd2; rwd = 8'h00;
      chk("b2b_ready_c1", 8'(rdy_m), 8'h00);
      @(negedge clk);
      chk("b2b_addr_latched", 8'(a_m), 8'h00);
      chk("b2b_wdata_latched", dat_m, 8'h11);
      repeat (2) @(negedge clk);
      chk("b2b_ready_c4", 8'(rdy_m), 8'h00);
      @(negedge clk);
      chk("b2b_rsp_c5",   8'(rsp_m), 8'h01);
      chk("b2b_ready_c5", 8'(rdy_m), 8'h01);
      chk("b2b_cs_gap",   8'(cs_m),  8'h01);
      chk("b2b_ppi_latch", seen[0], 8'h11);
      @(negedge clk);
      rv = 1'b0;
      chk("b2b_cs_c6",   8'(cs_m),   8'h00);
      chk("b2b_busy_c6", 8'(busy_m), 8'h01);
      chk("b2b_addr_c6", 8'(a_m),    8'h02);
      @(negedge clk);
      chk("b2b_rdb_c7", 8'(rdb_m), 8'h00);
      @(negedge clk);
      chk("b2b_rdb_c8", 8'(rdb_m), 8'h00);
      @(negedge clk);
      chk("b2b_rdb_c9", 8'(rdb_m), 8'h01);
      chk("b2b_rsp_c9", 8'(rsp_m), 8'h00);
      @(negedge clk);
      chk("b2b_rsp_c10",   8'(rsp_m), 8'h01);
      chk("b2b_rdata_c10", rd_m,      8'h98);

      // Stretched timing S=3, W=4, H=2.
      run_txn(1'b1, 3, 4, 2, 1'b1, 2'd1, 8'hA5, 8'h00);
      run_txn(1'b1, 3, 4, 2, 1'b0, 2'd2, 8'h00, 8'h98);

      // Reset in the middle of a write strobe.
      @(negedge clk);
      sel = 1'b0; rw = 1'b1; ra = 2'd1; rwd = 8'hE7; rv = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rv = 1'b0;
      @(negedge clk);
      chk("mid_wrb_low", 8'(wrb_m), 8'h00);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_wrb",   8'(wrb_m),  8'h01);
      chk("mid_rst_cs",    8'(cs_m),   8'h01);
      chk("mid_rst_busy",  8'(busy_m), 8'h00);
      chk("mid_rst_ready", 8'(rdy_m),  8'h00);
      chk("mid_rst_rsp",   8'(rsp_m),  8'h00);
      chk("mid_rst_rdata", rd_m,       8'h00);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("mid_no_rsp",    8'(rsp_m), 8'h00);
         chk("mid_ready_after", 8'(rdy_m), 8'h01);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ppi_bus_master.md
# ppi_bus_master

Synchronous initiator for the 8255-style PPI bus: accepts single read/write requests from a clocked host and drives the PPI's asynchronous bus pins (`cs`, `wrb`, `rdb`, `a1`, `a0`, tri-state `data`). It generates programmable setup, strobe and hold phases and returns captured read data on a one-cycle response. It sits between the core logic and a `ppi` instance, and is the only driver of that instance's bus pins.

## Interface
Parameters:
- `SETUP_CYCLES`, default 1: cycles with address, `cs` and write data valid before the strobe falls; legal range 1..15.
- `STROBE_CYCLES`, default 2: cycles `wrb`/`rdb` is held low; legal range 1..15.
- `HOLD_CYCLES`, default 1: cycles address, `cs` and write data stay valid after the strobe rises; legal range 1..15.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous active-high reset.
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_write`  in  1  1 = write cycle, 0 = read cycle.
- `req_addr`  in  2  PPI address: 00 port A, 01 port B, 10 port C, 11 control word.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle pulse: transaction finished.
- `rsp_rdata`  out  8  read data; valid while `rsp_valid`=1 after a read; holds its value until the next read completes.
- `busy`  out  1  transaction in progress (state ≠ IDLE).
- `cs`  out  1  PPI chip select, active low.
- `wrb`  out  1  PPI write strobe, active low.
- `rdb`  out  1  PPI read strobe, active low.
- `a1`, `a0`  out  1 each  PPI address.
- `data`  inout  8  PPI data bus; driven only during write transactions, otherwise high-Z.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. A single 4-bit down-counter times each phase.
- Latched request fields (write flag, address, write data) are captured at acceptance. Bus outputs come only from these registers and never from live `req_*` inputs.
- IDLE: `req_ready`=1, `cs`=`wrb`=`rdb`=1, `data` high-Z. A request is accepted when `req_valid`&`req_ready`. The FSM then moves to SETUP with the counter loaded to SETUP_CYCLES-1.
- SETUP: `cs`=0 and `a1`/`a0` = latched address. For a write, `data` is driven with latched wdata. When the counter reaches 0, the FSM moves to STROBE with the counter loaded to STROBE_CYCLES-1.
- STROBE: `wrb`=0 (write) or `rdb`=0 (read). Address, `cs` and data are unchanged. On the last STROBE edge of a read, `data` is sampled into `rsp_rdata`. The FSM then moves to HOLD.
- HOLD: both strobes are 1. Address, `cs` and write data are held. When the counter reaches 0, the FSM returns to IDLE and `rsp_valid` is set for one cycle.
- Writes leave `rsp_rdata` unchanged.
- Only one strobe is ever low, and a strobe is never low while `cs`=1.
- `a1`/`a0` keep their last value in IDLE; they do not toggle between transactions.
- Reset (any state): on that edge the FSM goes to IDLE, `cs`=`wrb`=`rdb`=1, `data` high-Z, `a1`=`a0`=0, `rsp_valid`=0, `rsp_rdata`=00, `busy`=0, `req_ready`=0 while `reset`=1.
  - An in-flight transaction is dropped with no response.
  - `req_valid` is ignored during reset.

## Timing
- Edge 0 = acceptance edge.
- SETUP occupies cycles 1..S, STROBE S+1..S+W, HOLD S+W+1..S+W+H.
- `rsp_valid`=1 and `req_ready`=1 in cycle S+W+H+1. With defaults this is cycle 5.
- Back-to-back: a new request may be accepted in the `rsp_valid` cycle. Throughput is then one transaction per S+W+H+1 cycles, with `cs` high for exactly that one IDLE cycle.
- Read capture uses data valid during the final strobe cycle, so the PPI access time must be less than W clock periods.
- The strobe edges (fall and rise) each fall on a clock edge. Address and data are stable for at least S cycles before the fall and H cycles after the rise.
- `req_ready` is 0 from cycle 1 through cycle S+W+H. Requests presented then are not accepted and must be held by the host.
- All outputs are registered, with no combinational path from `req_*` to the bus pins.

## Test plan
- Reset mid-STROBE of a write: `reset` is asserted → next cycle `wrb`=1, `cs`=1, `data`=Z, `rsp_valid` never pulses, `req_ready`=1 the cycle after `reset` falls.
- Control word write, addr 11, wdata 8'h80, defaults → `cs` falls at cycle 1, `wrb` low in cycles 2–3, `data`=80 in cycles 1–4, `rsp_valid` at cycle 5; the `ppi` model shows all ports as outputs.
- Port A write of 8'hBC after CW 8'h80 → `portA`=BC on the `ppi` model; `rsp_rdata` is unchanged.
- CW 8'h9B, then read port B driven with 8'h35 externally → `rdb` low in cycles 2–3, `data` undriven by the master, `rsp_rdata`=35 with `rsp_valid`.
- Back-to-back: `req_valid` held high for a write then a read (port C = 8'h98) → second acceptance in the first response cycle, single-cycle `cs` high gap, `rsp_rdata`=98.
- Parameters S=3, W=4, H=2 → `rsp_valid` at cycle 10 after acceptance; strobe low in cycles 4–7 exactly; never both strobes low; `cs`=0 whenever a strobe is low.
